// File: rtl/shreg_tx_ctrl.sv
// Framed parallel-in/serial-out transmitter: start bit, WIDTH data bits LSB first,
// optional even parity (compile with SHREG_TX_PARITY_EN), stop bit. sout idles high.
module shreg_tx_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             r,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef SHREG_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
`ifdef SHREG_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
`ifdef SHREG_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
`ifdef SHREG_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Outputs are decoded from registered state only, so load/din never reach them.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
`ifdef SHREG_TX_PARITY_EN
        parity_d = parity_q;
`endif
        ready    = 1'b0;
        sout     = 1'b1;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    shreg_d  = din;
                    cnt_d    = '0;
`ifdef SHREG_TX_PARITY_EN
                    parity_d = 1'b0;
`endif
                    state_d  = START;
                end
            end
            START: begin
                sout    = 1'b0;
                state_d = DATA;
            end
            DATA: begin
                sout     = shreg_q[0];
                shreg_d  = {1'b0, shreg_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CW'(1);
`ifdef SHREG_TX_PARITY_EN
                parity_d = parity_q ^ shreg_q[0];
                if (cnt_q == LAST_BIT) state_d = PAR;
`else
                if (cnt_q == LAST_BIT) state_d = STOP;
`endif
            end
`ifdef SHREG_TX_PARITY_EN
            PAR: begin
                sout    = parity_q;
                state_d = STOP;
            end
`endif
            STOP: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shreg_tx_ctrl.sv
// Bench for shreg_tx_ctrl: queue-of-frame-bits reference model plus literal frame checks.
// Build with SHREG_TX_PARITY_EN defined to exercise the parity variant.
module tb_shreg_tx_ctrl;
    localparam int W = 8;
`ifdef SHREG_TX_PARITY_EN
    localparam int FL = W + 3;
`else
    localparam int FL = W + 2;
`endif

    logic         clk = 1'b0;
    logic         r = 1'b1;
    logic [W-1:0] din = '0;
    logic         load = 1'b0;
    logic         ready, sout, done;

    int checks = 0;
    int errors = 0;

    shreg_tx_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .r     (r),
        .din   (din),
        .load  (load),
        .ready (ready),
        .sout  (sout),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the remaining bits of the frame in flight, front = bit now on the line.
    bit mq[$];
    always @(posedge clk or posedge r) begin
        if (r) begin
            mq.delete();
        end else if (mq.size() > 0) begin
            void'(mq.pop_front());
        end else if (load) begin
            mq.push_back(1'b0);
            for (int i = 0; i < W; i++) mq.push_back(din[i]);
`ifdef SHREG_TX_PARITY_EN
            mq.push_back(^din);
`endif
            mq.push_back(1'b1);
        end
    end

    always @(negedge clk) begin
        chk("model_sout", 32'(sout), (mq.size() == 0) ? 32'd1 : 32'(mq[0]));
        chk("model_ready", 32'(ready), 32'(mq.size() == 0));
        chk("model_done", 32'(done), 32'(mq.size() == 1));
    end

    // Sends one frame from idle and pins the serial sequence (first bit at MSB side).
    task automatic frame_lit(input logic [W-1:0] d, input int poke, input logic [15:0] exp,
                             input string nm);
        logic [15:0] got, rdy, dn;
        got = '0; rdy = '0; dn = '0;
        @(negedge clk);
        load = 1'b1; din = d;
        @(negedge clk);
        load = 1'b0; din = W'($urandom);
        for (int i = 0; i < FL; i++) begin
            got = {got[14:0], sout};
            rdy = {rdy[14:0], ready};
            dn  = {dn[14:0], done};
            if (i == poke) begin
                load = 1'b1; din = '1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        chk({nm, "_bits"}, 32'(got), 32'(exp));
        chk({nm, "_busy"}, 32'(rdy), 32'd0);
        chk({nm, "_done"}, 32'(dn), 32'd1);
        chk({nm, "_idle"}, {30'd0, ready, sout}, 32'd3);
        $display("frame %s din=%0h bits=%0h", nm, d, got);
    endtask

    initial begin
        logic [15:0] got;
        int nrdy;

        #1;
        chk("rst_sout", 32'(sout), 32'd1);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        #1 r = 1'b0;

        // Async reset while idle: outputs hold idle values without a clock edge.
        @(negedge clk);
        #2 r = 1'b1;
        #1 chk("idle_rst", {29'd0, sout, ready, done}, 32'b110);
        r = 1'b0;

`ifdef SHREG_TX_PARITY_EN
        frame_lit(8'hA5, 3, 16'b01010010101, "a5_par");
        frame_lit(8'h07, -1, 16'b01110000011, "07_par");
`else
        frame_lit(8'hA5, 3, 16'b0101001011, "a5");
`endif

        // Back-to-back with load held high: frame, one idle cycle, next start bit.
        @(negedge clk);
        load = 1'b1; din = 8'h01;
        @(negedge clk);
        got = '0; nrdy = 0;
        for (int i = 0; i < FL + 2; i++) begin
            got = {got[14:0], sout};
            nrdy += 32'(ready);
            @(negedge clk);
        end
        load = 1'b0;
`ifdef SHREG_TX_PARITY_EN
        chk("b2b_bits", 32'(got), 32'b0100000001110);
`else
        chk("b2b_bits", 32'(got), 32'b010000000110);
`endif
        chk("b2b_idle_cycles", 32'(nrdy), 32'd1);
        $display("back-to-back bits=%0h idle=%0d", got, nrdy);
        repeat (FL + 2) @(negedge clk);

        // Mid-frame reset during data bit 4, with a load request while r is high.
        @(negedge clk);
        load = 1'b1; din = 8'h00;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        #2 r = 1'b1;
        #1 chk("midrst", {29'd0, sout, ready, done}, 32'b110);
        @(negedge clk);
        load = 1'b1; din = W'($urandom);
        @(negedge clk);
        #1 r = 1'b0; load = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(ready), 32'd1);
        $display("mid-frame reset handled");
`ifdef SHREG_TX_PARITY_EN
        frame_lit(8'h3C, -1, 16'b00011110001, "3c_par");
`else
        frame_lit(8'h3C, -1, 16'b0001111001, "3c");
`endif

        // Random traffic, including occasional async reset pulses between edges.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            load = ($urandom_range(0, 2) == 0);
            din  = W'($urandom);
            if ($urandom_range(0, 60) == 0) begin
                #1 r = 1'b1;
                #2 r = 1'b0;
            end
        end
        load = 1'b0;
        repeat (FL + 2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
